// File: rtl/uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// uart_cmd_rx
//
// UART receiver and command decoder for the synth control path. Bytes arrive
// on uart_rxd as 8N1 frames. They are grouped into fixed-length command
// packets that drive the wave width, the UI reload trigger, the note gate and
// the playback rate of oscillator 0.
//
// Packet layout: 0xA5 sync, CMD, D2, D1, D0 [, CHK]. DATA = {D2, D1, D0}.
// Compile-time option:
//   UART_CMD_CHECKSUM_EN  defined   -> 6-byte packets; CHK = CMD^D2^D1^D0 is
//                                      verified before execution.
//                         undefined -> 5-byte packets with no CHK byte.
//
// Ports:
//   clk_in              in   system clock (the only clock)
//   rst_in              in   synchronous, active-low reset
//   uart_rxd            in   asynchronous serial line, idles high
//   wave_width_out      out  current wave width (WW_WIDTH bits, resets to 1024)
//   ui_update_trig_out  out  one-cycle pulse: reload waveform
//   is_note_on_out      out  note gate for oscillator 0
//   playback_rate_out   out  24-bit phase increment for oscillator 0
//   cmd_valid_out       out  one-cycle pulse: packet accepted
//   cmd_error_out       out  one-cycle pulse: packet rejected (framing,
//                            checksum, unknown command, bad value, timeout)
// -----------------------------------------------------------------------------
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BAUD = 868,
  parameter int unsigned WW_WIDTH      = 18,
  parameter int unsigned TIMEOUT_BAUDS = 20
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                uart_rxd,
  output logic [WW_WIDTH-1:0] wave_width_out,
  output logic                ui_update_trig_out,
  output logic                is_note_on_out,
  output logic [23:0]         playback_rate_out,
  output logic                cmd_valid_out,
  output logic                cmd_error_out
);

  localparam int unsigned         BAUD_W    = $clog2(CLKS_PER_BAUD);
  localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BAUD - 1);
  localparam logic [BAUD_W-1:0]   HALF_LAST = BAUD_W'(CLKS_PER_BAUD / 2 - 1);
  localparam int unsigned         TO_LIMIT  = TIMEOUT_BAUDS * CLKS_PER_BAUD;
  localparam int unsigned         TO_W      = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TO_LIMIT);
  localparam logic [WW_WIDTH-1:0] WW_RESET  = WW_WIDTH'(1024);

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam logic [7:0] CMD_SET_WIDTH = 8'h01;
  localparam logic [7:0] CMD_NOTE_ON   = 8'h02;
  localparam logic [7:0] CMD_NOTE_OFF  = 8'h03;
  localparam logic [7:0] CMD_UI_TRIG   = 8'h04;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_BREAK     // framing error seen; wait for the line to return high
  } bit_state_e;

  typedef enum logic [2:0] {
    P_WAIT_SYNC,
    P_CMD,
    P_D2,
    P_D1,
    P_D0,
`ifdef UART_CMD_CHECKSUM_EN
    P_CHK,
`endif
    P_EXEC
  } pkt_state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser. All three stages reset to the idle (high) level so
  // that leaving reset never looks like a start-bit falling edge.
  // ---------------------------------------------------------------------------
  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit FSM: deserialises one 8N1 frame, sampling mid-bit.
  // ---------------------------------------------------------------------------
  bit_state_e        bstate_q, bstate_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_valid;
  logic              framing_err;

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    bstate_d    = bstate_q;
    baud_cnt_d  = baud_cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_valid  = 1'b0;
    framing_err = 1'b0;

    case (bstate_q)
      B_IDLE: begin
        baud_cnt_d = '0;
        if (rxd_prev_q && !rxd_sync_q) bstate_d = B_START;
      end
      B_START: begin
        // Half a bit in: still low means a real start bit, high is a glitch.
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          bstate_d   = rxd_sync_q ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {rxd_sync_q, shift_q[7:1]};  // LSB arrives first
          bit_idx_d  = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) bstate_d = B_STOP;
        end
      end
      B_STOP: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (rxd_sync_q) begin
            byte_valid = 1'b1;
            bstate_d   = B_IDLE;
          end else begin
            framing_err = 1'b1;
            bstate_d    = B_BREAK;
          end
        end
      end
      B_BREAK: begin
        baud_cnt_d = '0;
        if (rxd_sync_q) bstate_d = B_IDLE;
      end
      default: bstate_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      bstate_q   <= B_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      bstate_q   <= bstate_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet FSM, inter-byte timeout and command execution.
  // ---------------------------------------------------------------------------
  pkt_state_e         pstate_q, pstate_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [23:0]        data_q, data_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [WW_WIDTH-1:0] ww_q, ww_d;
  logic [23:0]        rate_q, rate_d;
  logic               note_q, note_d;
  logic               trig_q, trig_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               in_packet;
  logic               timeout_hit;
  logic               chk_ok;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]         chk_q, chk_d;
`endif

  // The timeout only runs while a packet is partially received.
  assign in_packet   = (pstate_q != P_WAIT_SYNC) && (pstate_q != P_EXEC);
  assign timeout_hit = in_packet && (to_cnt_q == TO_LAST);

  always_comb begin
`ifdef UART_CMD_CHECKSUM_EN
    chk_ok = (chk_q == (cmd_q ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0]));
`else
    chk_ok = 1'b1;
`endif
  end

  always_comb begin
    pstate_d = pstate_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    to_cnt_d = '0;
    ww_d     = ww_q;
    rate_d   = rate_q;
    note_d   = note_q;
    trig_d   = 1'b0;
    valid_d  = 1'b0;
    err_d    = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    chk_d    = chk_q;
`endif

    if (in_packet && !byte_valid) to_cnt_d = to_cnt_q + 1'b1;

    // Framing error and timeout share one error pulse even if they coincide.
    if (framing_err || timeout_hit) begin
      err_d    = 1'b1;
      to_cnt_d = '0;
      pstate_d = P_WAIT_SYNC;
    end else begin
      case (pstate_q)
        P_WAIT_SYNC: begin
          if (byte_valid && shift_q == SYNC_BYTE) pstate_d = P_CMD;
        end
        P_CMD: begin
          if (byte_valid) begin
            cmd_d    = shift_q;
            pstate_d = P_D2;
          end
        end
        P_D2: begin
          if (byte_valid) begin
            data_d[23:16] = shift_q;
            pstate_d      = P_D1;
          end
        end
        P_D1: begin
          if (byte_valid) begin
            data_d[15:8] = shift_q;
            pstate_d     = P_D0;
          end
        end
        P_D0: begin
          if (byte_valid) begin
            data_d[7:0] = shift_q;
`ifdef UART_CMD_CHECKSUM_EN
            pstate_d    = P_CHK;
`else
            pstate_d    = P_EXEC;
`endif
          end
        end
`ifdef UART_CMD_CHECKSUM_EN
        P_CHK: begin
          if (byte_valid) begin
            chk_d    = shift_q;
            pstate_d = P_EXEC;
          end
        end
`endif
        P_EXEC: begin
          pstate_d = P_WAIT_SYNC;
          if (!chk_ok) begin
            err_d = 1'b1;
          end else begin
            case (cmd_q)
              CMD_SET_WIDTH: begin
                // Width must fit the register and must not be zero.
                if (((data_q >> WW_WIDTH) == '0) && (data_q != '0)) begin
                  ww_d    = data_q[WW_WIDTH-1:0];
                  trig_d  = 1'b1;
                  valid_d = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
              CMD_NOTE_ON: begin
                rate_d  = data_q;
                note_d  = 1'b1;
                valid_d = 1'b1;
              end
              CMD_NOTE_OFF: begin
                note_d  = 1'b0;
                valid_d = 1'b1;
              end
              CMD_UI_TRIG: begin
                trig_d  = 1'b1;
                valid_d = 1'b1;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        default: pstate_d = P_WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pstate_q <= P_WAIT_SYNC;
      cmd_q    <= '0;
      data_q   <= '0;
      to_cnt_q <= '0;
      ww_q     <= WW_RESET;
      rate_q   <= '0;
      note_q   <= 1'b0;
      trig_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      pstate_q <= pstate_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      to_cnt_q <= to_cnt_d;
      ww_q     <= ww_d;
      rate_q   <= rate_d;
      note_q   <= note_d;
      trig_q   <= trig_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef UART_CMD_CHECKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  assign wave_width_out     = ww_q;
  assign playback_rate_out  = rate_q;
  assign is_note_on_out     = note_q;
  assign ui_update_trig_out = trig_q;
  assign cmd_valid_out      = valid_q;
  assign cmd_error_out      = err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_rx
//
// Directed bench for uart_cmd_rx. The stimulus thread sends UART frames and,
// before each packet, pushes the response it should produce into a queue.
// A monitor thread pops and compares whenever the DUT pulses cmd_valid_out,
// cmd_error_out or ui_update_trig_out. A short bit period keeps runtime low.
// -----------------------------------------------------------------------------
module tb_uart_cmd_rx;

  localparam int CPB      = 16;
  localparam int WW       = 18;
  localparam int TO_BAUDS = 20;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          uart_rxd;
  logic [WW-1:0] wave_width_out;
  logic          ui_update_trig_out;
  logic          is_note_on_out;
  logic [23:0]   playback_rate_out;
  logic          cmd_valid_out;
  logic          cmd_error_out;

  uart_cmd_rx #(
    .CLKS_PER_BAUD(CPB),
    .WW_WIDTH     (WW),
    .TIMEOUT_BAUDS(TO_BAUDS)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .uart_rxd          (uart_rxd),
    .wave_width_out    (wave_width_out),
    .ui_update_trig_out(ui_update_trig_out),
    .is_note_on_out    (is_note_on_out),
    .playback_rate_out (playback_rate_out),
    .cmd_valid_out     (cmd_valid_out),
    .cmd_error_out     (cmd_error_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    bit          trig;
    logic [WW-1:0] ww;
    logic [23:0] rate;
    bit          note;
    int          lo;   // earliest allowed cycle (0 = unchecked)
    int          hi;   // latest allowed cycle   (0 = unchecked)
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the control registers.
  logic [WW-1:0] m_ww   = WW'(1024);
  logic [23:0]   m_rate = '0;
  bit            m_note = 1'b0;

  int stop_start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input string name, input bit err, input bit trig,
                          input int lo = 0, input int hi = 0);
    exp_t e;
    e.err  = err;
    e.trig = trig;
    e.ww   = m_ww;
    e.rate = m_rate;
    e.note = m_note;
    e.lo   = lo;
    e.hi   = hi;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic idle_bits(input int n);
    uart_rxd = 1'b1;
    repeat (n * CPB) @(negedge clk_in);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk_in);
    end
    uart_rxd       = stop;
    stop_start_cyc = cyc;
    repeat (CPB) @(negedge clk_in);
    uart_rxd = 1'b1;
  endtask

  task automatic send_packet(input logic [7:0] cmd, input logic [7:0] d2,
                             input logic [7:0] d1, input logic [7:0] d0,
                             input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(d2);
    send_byte(d1);
    send_byte(d0);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(chk);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " wave_width"}, 32'(wave_width_out), 32'd1024);
    check({tag, " rate"},       32'(playback_rate_out), 32'd0);
    check({tag, " note"},       32'(is_note_on_out), 32'd0);
    check({tag, " valid"},      32'(cmd_valid_out), 32'd0);
    check({tag, " error"},      32'(cmd_error_out), 32'd0);
    check({tag, " trig"},       32'(ui_update_trig_out), 32'd0);
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  exp_t  mon_e;
  string mon_n;
  always @(negedge clk_in) begin
    if (cmd_valid_out || cmd_error_out || ui_update_trig_out) begin
      if (exp_q.size() == 0) begin
        check($sformatf("unexpected pulse at cycle %0d {valid,err,trig}", cyc),
              32'({cmd_valid_out, cmd_error_out, ui_update_trig_out}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check({mon_n, " valid"},      32'(cmd_valid_out), 32'(!mon_e.err));
        check({mon_n, " error"},      32'(cmd_error_out), 32'(mon_e.err));
        check({mon_n, " trig"},       32'(ui_update_trig_out), 32'(mon_e.trig));
        check({mon_n, " wave_width"}, 32'(wave_width_out), 32'(mon_e.ww));
        check({mon_n, " rate"},       32'(playback_rate_out), 32'(mon_e.rate));
        check({mon_n, " note"},       32'(is_note_on_out), 32'(mon_e.note));
        if (mon_e.hi != 0)
          check($sformatf("%s cycle %0d within [%0d,%0d]", mon_n, cyc, mon_e.lo, mon_e.hi),
                32'(cyc >= mon_e.lo && cyc <= mon_e.hi), 32'd1);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk_in);
    $display("FAIL watchdog: stimulus did not complete within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    uart_rxd = 1'b1;
    rst_in   = 1'b0;
    repeat (5) @(negedge clk_in);
    rst_in = 1'b1;
    idle_bits(10);
    check_idle_outputs("reset");

    // Accepted commands.
    m_ww = WW'(18'h00800);
    exp_push("set width 0x800", 1'b0, 1'b1);
    send_packet(8'h01, 8'h00, 8'h08, 8'h00, 8'h09);

    m_rate = 24'h012345; m_note = 1'b1;
    exp_push("note on", 1'b0, 1'b0);
    send_packet(8'h02, 8'h01, 8'h23, 8'h45, 8'h65);

    m_note = 1'b0;
    exp_push("note off", 1'b0, 1'b0);
    send_packet(8'h03, 8'h00, 8'h00, 8'h00, 8'h03);

    exp_push("ui trig", 1'b0, 1'b1);
    send_packet(8'h04, 8'h00, 8'h00, 8'h00, 8'h04);

    // Rejected commands leave the model untouched.
    exp_push("bad width", 1'b1, 1'b0);
    send_packet(8'h01, 8'h04, 8'h00, 8'h00, 8'h05);

    exp_push("zero width", 1'b1, 1'b0);
    send_packet(8'h01, 8'h00, 8'h00, 8'h00, 8'h01);

    exp_push("unknown cmd", 1'b1, 1'b0);
    send_packet(8'h07, 8'h00, 8'h00, 8'h00, 8'h07);

`ifdef UART_CMD_CHECKSUM_EN
    exp_push("checksum mismatch", 1'b1, 1'b0);
    send_packet(8'h02, 8'h01, 8'h23, 8'h45, 8'h00);
`endif

    // Largest width that fits.
    m_ww = WW'(18'h3FFFF);
    exp_push("max width", 1'b0, 1'b1);
    send_packet(8'h01, 8'h03, 8'hFF, 8'hFF, 8'h02);

    // Junk before sync is dropped; 0xA5 inside a packet is plain data.
    send_byte(8'h11);
    send_byte(8'h5A);
    m_rate = 24'hA5A5A5; m_note = 1'b1;
    exp_push("A5 as data", 1'b0, 1'b0);
    send_packet(8'h02, 8'hA5, 8'hA5, 8'hA5, 8'hA7);

    // Framing error mid-packet, then recovery.
    exp_push("framing error", 1'b1, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h02, 1'b0);
    idle_bits(2);
    m_note = 1'b0;
    exp_push("after framing", 1'b0, 1'b0);
    send_packet(8'h03, 8'h00, 8'h00, 8'h00, 8'h03);

    // Timeout: error about 20 bit periods after the last stop sample.
    send_byte(8'hA5);
    send_byte(8'h02);
    exp_push("timeout", 1'b1, 1'b0,
             stop_start_cyc + CPB / 2 + TO_BAUDS * CPB - 2,
             stop_start_cyc + CPB / 2 + TO_BAUDS * CPB + 10);
    idle_bits(25);

    // Short glitch must not start a byte.
    uart_rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk_in);
    idle_bits(4);
    exp_push("after glitch", 1'b0, 1'b1);
    send_packet(8'h04, 8'h00, 8'h00, 8'h00, 8'h04);

    // Reset in the middle of a byte, in the middle of a packet.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h01);
    uart_rxd = 1'b0;
    repeat (CPB * 3) @(negedge clk_in);
    rst_in   = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    m_ww = WW'(1024); m_rate = '0; m_note = 1'b0;
    check_idle_outputs("mid-packet reset");
    idle_bits(2);
    m_rate = 24'h001000; m_note = 1'b1;
    exp_push("after reset", 1'b0, 1'b0);
    send_packet(8'h02, 8'h00, 8'h10, 8'h00, 8'h12);

    idle_bits(4);
    check("responses outstanding", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
